npu_layer_sequencer: RTL and testbench

// - Sequences one NPU layer pass: RAM -> A buffer load, systolic MAC, Leaky ReLU,

---
 rtl/npu_layer_sequencer.sv | 253 +++++++++++++++++++++++++
 tb/tb_npu_layer_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_layer_sequencer.sv
// npu_layer_sequencer: runs one NPU layer pass. It loads the A buffer from RAM,
// kicks the systolic MAC, Leaky ReLU and normalization stages in turn, then
// writes the N x N result matrix back to RAM.
// Build option: define NPU_SEQ_WATCHDOG_EN to add a per-stage timeout watchdog
// that aborts a hung stage into ERROR and raises the sticky err flag.
module npu_layer_sequencer #(
  parameter int N        = 10,
  parameter int DW       = 16,
  parameter int AW       = 16,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 100,
  parameter int TIMEOUT  = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rd_en,
  input  logic [DW-1:0] ram_rdata,
  output logic          ram_wr_en,
  output logic [DW-1:0] ram_wdata,
  output logic          ld_valid,
  output logic [3:0]    ld_row,
  output logic [3:0]    ld_col,
  output logic [DW-1:0] ld_data,
  output logic          sa_start,
  output logic          relu_start,
  output logic          norm_start,
  input  logic          sa_done,
  input  logic          relu_done,
  input  logic          norm_done,
  output logic [3:0]    res_row,
  output logic [3:0]    res_col,
  input  logic [DW-1:0] res_data
);

  localparam int              NN       = N * N;
  localparam int              KW       = $clog2(NN + 1);
  localparam logic [KW-1:0]   K_LAST   = KW'(NN - 1);
  localparam logic [3:0]      COL_LAST = 4'(N - 1);
  localparam logic [AW-1:0]   SRC_A    = AW'(SRC_BASE);
  localparam logic [AW-1:0]   DST_A    = AW'(DST_BASE);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_LOAD_DRAIN, S_MAC, S_RELU, S_NORM, S_STORE, S_DONE, S_ERROR
  } state_t;

  state_t        state_q;
  logic          start_q;
  logic          req;
  logic [KW-1:0] k_q;
  logic [3:0]    row_q, col_q;
  logic          busy_q, done_q, rd_en_q, wr_en_q, ld_valid_q;
  logic          sa_start_q, relu_start_q, norm_start_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [3:0]    ld_row_q, ld_col_q;
  logic          stage_done;
  logic [KW-1:0] k_inc;
  logic [3:0]    row_inc, col_inc;

`ifdef NPU_SEQ_WATCHDOG_EN
  localparam int            CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] wd_q;
  logic          err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Only the rising edge of the start button requests a pass.
  assign req = start & ~start_q;

  // Stage completion, masked in the cycle the stage start pulse is out.
  always_comb begin
    stage_done = 1'b0;
    case (state_q)
      S_MAC:   stage_done = sa_done   & ~sa_start_q;
      S_RELU:  stage_done = relu_done & ~relu_start_q;
      S_NORM:  stage_done = norm_done & ~norm_start_q;
      default: stage_done = 1'b0;
    endcase
  end

  // Next linear index and its row/column, shared by LOAD and STORE.
  always_comb begin
    k_inc = k_q + KW'(1);
    if (col_q == COL_LAST) begin
      col_inc = 4'd0;
      row_inc = row_q + 4'd1;
    end else begin
      col_inc = col_q + 4'd1;
      row_inc = row_q;
    end
  end

  // Sequencer FSM; every output except res_row/res_col comes from a register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      start_q      <= 1'b0;
      k_q          <= '0;
      row_q        <= '0;
      col_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      ld_valid_q   <= 1'b0;
      sa_start_q   <= 1'b0;
      relu_start_q <= 1'b0;
      norm_start_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ld_row_q     <= '0;
      ld_col_q     <= '0;
`ifdef NPU_SEQ_WATCHDOG_EN
      wd_q         <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      start_q      <= start;
      done_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      ld_valid_q   <= 1'b0;
      sa_start_q   <= 1'b0;
      relu_start_q <= 1'b0;
      norm_start_q <= 1'b0;
      if (abort && state_q != S_IDLE) begin
        // Abort beats any stage done; strobes drop through the defaults above.
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (req) begin
              state_q <= S_LOAD;
              busy_q  <= 1'b1;
              k_q     <= '0;
              row_q   <= '0;
              col_q   <= '0;
              rd_en_q <= 1'b1;
              addr_q  <= SRC_A;
`ifdef NPU_SEQ_WATCHDOG_EN
              err_q   <= 1'b0;
`endif
            end
          end
          S_LOAD: begin
            // The read issued now returns next cycle, alongside its ld_* tag.
            ld_valid_q <= 1'b1;
            ld_row_q   <= row_q;
            ld_col_q   <= col_q;
            if (k_q == K_LAST) begin
              state_q <= S_LOAD_DRAIN;
            end else begin
              k_q     <= k_inc;
              row_q   <= row_inc;
              col_q   <= col_inc;
              rd_en_q <= 1'b1;
              addr_q  <= SRC_A + AW'(k_inc);
            end
          end
          S_LOAD_DRAIN: begin
            state_q    <= S_MAC;
            sa_start_q <= 1'b1;
`ifdef NPU_SEQ_WATCHDOG_EN
            wd_q       <= '0;
`endif
          end
          S_MAC, S_RELU, S_NORM: begin
            if (stage_done) begin
`ifdef NPU_SEQ_WATCHDOG_EN
              wd_q <= '0;
`endif
              if (state_q == S_MAC) begin
                state_q      <= S_RELU;
                relu_start_q <= 1'b1;
              end else if (state_q == S_RELU) begin
                state_q      <= S_NORM;
                norm_start_q <= 1'b1;
              end else begin
                state_q <= S_STORE;
                k_q     <= '0;
                row_q   <= '0;
                col_q   <= '0;
              end
            end
`ifdef NPU_SEQ_WATCHDOG_EN
            else if (wd_q == WD_LAST) begin
              state_q <= S_ERROR;
              err_q   <= 1'b1;
            end else begin
              wd_q <= wd_q + CW'(1);
            end
`endif
          end
          S_STORE: begin
            // res_data answers the current res_row/res_col in this same cycle.
            wr_en_q <= 1'b1;
            addr_q  <= DST_A + AW'(k_q);
            wdata_q <= res_data;
            if (k_q == K_LAST) begin
              state_q <= S_DONE;
            end else begin
              k_q   <= k_inc;
              row_q <= row_inc;
              col_q <= col_inc;
            end
          end
          S_DONE: begin
            // The last write is on the bus this cycle; done follows it.
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          S_ERROR: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign ram_addr   = addr_q;
  assign ram_rd_en  = rd_en_q;
  assign ram_wr_en  = wr_en_q;
  assign ram_wdata  = wdata_q;
  assign ld_valid   = ld_valid_q;
  assign ld_row     = ld_row_q;
  assign ld_col     = ld_col_q;
  // ram_rdata is the RAM's own output register; gating keeps ld_data 0 when idle.
  assign ld_data    = ld_valid_q ? ram_rdata : '0;
  assign sa_start   = sa_start_q;
  assign relu_start = relu_start_q;
  assign norm_start = norm_start_q;
  assign res_row    = row_q;
  assign res_col    = col_q;

endmodule

// File: tb/tb_npu_layer_sequencer.sv
// tb_npu_layer_sequencer: table-driven passes with varied stage delays plus
// hand sequences for abort in STORE, async reset in LOAD and stage timeout.
module tb_npu_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done, err;
  logic [15:0] ram_addr;
  logic        ram_rd_en, ram_wr_en;
  logic [15:0] ram_rdata = '0;
  logic [15:0] ram_wdata;
  logic        ld_valid;
  logic [3:0]  ld_row, ld_col, res_row, res_col;
  logic [15:0] ld_data, res_data;
  logic        sa_start, relu_start, norm_start;
  logic        sa_done, relu_done, norm_done;

  npu_layer_sequencer #(
    .N(10), .DW(16), .AW(16), .SRC_BASE(0), .DST_BASE(100), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .err(err),
    .ram_addr(ram_addr), .ram_rd_en(ram_rd_en), .ram_rdata(ram_rdata),
    .ram_wr_en(ram_wr_en), .ram_wdata(ram_wdata),
    .ld_valid(ld_valid), .ld_row(ld_row), .ld_col(ld_col), .ld_data(ld_data),
    .sa_start(sa_start), .relu_start(relu_start), .norm_start(norm_start),
    .sa_done(sa_done), .relu_done(relu_done), .norm_done(norm_done),
    .res_row(res_row), .res_col(res_col), .res_data(res_data)
  );

  always #5 clk = ~clk;

  // Expected normalized result at linear index k (row k/10, column k%10).
  function automatic logic [15:0] exp_res(input int k);
    return 16'((k / 10) * 37 + (k % 10) * 5 + 1000);
  endfunction

  // Result-buffer stand-in: element value depends on row and column.
  assign res_data = 16'(int'(res_row) * 37 + int'(res_col) * 5 + 1000);

  // RAM with one-cycle read latency; clr_req reloads source, poisons destination.
  logic        clr_req = 1'b0;
  logic [15:0] mem [0:255];
  always @(posedge clk) begin
    if (clr_req) begin
      for (int i = 0; i < 256; i++)
        mem[i] <= (i < 100) ? 16'(i / 10 + i % 10) : 16'hDEAD;
    end else if (ram_wr_en) begin
      mem[ram_addr[7:0]] <= ram_wdata;
    end
    if (ram_rd_en) ram_rdata <= mem[ram_addr[7:0]];
  end

  // Stage responders: done rises dly cycles after the start pulse; echo also
  // raises done in the start cycle itself; never suppresses the delayed done.
  int          stg_dly [3];
  bit          stg_never [3];
  bit          stg_echo [3];
  logic [2:0]  stg_start, stg_done;
  assign stg_start = {norm_start, relu_start, sa_start};
  for (genvar gi = 0; gi < 3; gi++) begin : g_stage
    int cnt;
    always @(posedge clk or posedge rst) begin
      if (rst)                cnt <= 0;
      else if (stg_start[gi]) cnt <= 1;
      else if (cnt != 0)      cnt <= cnt + 1;
    end
    assign stg_done[gi] = (!stg_never[gi] && cnt == stg_dly[gi]) ||
                          (stg_echo[gi] && stg_start[gi]);
  end
  assign sa_done   = stg_done[0];
  assign relu_done = stg_done[1];
  assign norm_done = stg_done[2];

  // Monitor: counts beats, pulses and writes, flags out-of-order data.
  int cyc = 0;
  int ld_beats, ld_errs, wr_cnt, wr_errs, done_cnt;
  int sa_pulses, relu_pulses, norm_pulses, sa_cyc, relu_cyc, norm_cyc;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (ld_valid) begin
      if (ld_row != 4'(ld_beats / 10) || ld_col != 4'(ld_beats % 10) ||
          ld_data != 16'(ld_beats / 10 + ld_beats % 10))
        ld_errs++;
      ld_beats++;
    end
    if (ram_wr_en) begin
      if (ram_addr != 16'(100 + wr_cnt) || ram_wdata != exp_res(wr_cnt))
        wr_errs++;
      wr_cnt++;
    end
    if (sa_start)   begin sa_pulses++;   sa_cyc   = cyc; end
    if (relu_start) begin relu_pulses++; relu_cyc = cyc; end
    if (norm_start) begin norm_pulses++; norm_cyc = cyc; end
    if (done) done_cnt++;
  end

  int n_vec = 0;
  int n_err = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    ld_beats = 0; ld_errs = 0; wr_cnt = 0; wr_errs = 0; done_cnt = 0;
    sa_pulses = 0; relu_pulses = 0; norm_pulses = 0;
    sa_cyc = 0; relu_cyc = 0; norm_cyc = 0;
  endtask

  function automatic int ram_errs();
    int e = 0;
    for (int k = 0; k < 100; k++)
      if (mem[100 + k] != exp_res(k)) e++;
    return e;
  endfunction

  // Hold start for 'hold' cycles, then wait (bounded) for the done pulse.
  task automatic run_pass(input int hold);
    clear_mon();
    start = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c == hold - 1) start = 1'b0;
      if (c >= hold && done_cnt > 0) break;
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  typedef struct {
    int sa_d;
    int relu_d;
    int norm_d;
    int hold;
    bit sa_echo;
    int exp_gap_sr;
    int exp_gap_rn;
  } vec_t;

  vec_t vt [5];
  int   found;

  initial begin
    vt[0] = '{5, 5, 5,   1, 1'b0, 6,  6};
    vt[1] = '{1, 2, 3,   4, 1'b0, 2,  3};
    vt[2] = '{7, 1, 4, 500, 1'b0, 8,  2};
    vt[3] = '{3, 2, 2,   1, 1'b1, 4,  3};
    vt[4] = '{2, 9, 1,   3, 1'b0, 3, 10};
    for (int i = 0; i < 3; i++) begin
      stg_dly[i] = 5; stg_never[i] = 1'b0; stg_echo[i] = 1'b0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy",   32'(busy), 0);
    check("rst_done",   32'(done), 0);
    check("rst_err",    32'(err), 0);
    check("rst_rd_en",  32'(ram_rd_en), 0);
    check("rst_wr_en",  32'(ram_wr_en), 0);
    check("rst_ld_val", 32'(ld_valid), 0);
    check("rst_sa",     32'(sa_start), 0);
    check("rst_addr",   32'(ram_addr), 0);
    check("rst_ld_data",32'(ld_data), 0);
    $display("reset: outputs checked, busy=%0d done=%0d err=%0d", busy, done, err);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven full passes
    for (int v = 0; v < 5; v++) begin
      stg_dly[0] = vt[v].sa_d; stg_dly[1] = vt[v].relu_d; stg_dly[2] = vt[v].norm_d;
      stg_echo[0] = vt[v].sa_echo;
      run_pass(vt[v].hold);
      check("ld_beats",    ld_beats, 100);
      check("ld_order",    ld_errs, 0);
      check("writes",      wr_cnt, 100);
      check("write_order", wr_errs, 0);
      check("sa_pulses",   sa_pulses, 1);
      check("relu_pulses", relu_pulses, 1);
      check("norm_pulses", norm_pulses, 1);
      check("done_pulses", done_cnt, 1);
      check("gap_sa_relu", relu_cyc - sa_cyc, vt[v].exp_gap_sr);
      check("gap_relu_nm", norm_cyc - relu_cyc, vt[v].exp_gap_rn);
      check("busy_after",  32'(busy), 0);
      check("err_after",   32'(err), 0);
      check("ram_result",  ram_errs(), 0);
      $display("vec %0d: dly=%0d/%0d/%0d hold=%0d echo=%0d ld=%0d wr=%0d done=%0d",
               v, vt[v].sa_d, vt[v].relu_d, vt[v].norm_d, vt[v].hold,
               vt[v].sa_echo, ld_beats, wr_cnt, done_cnt);
    end
    stg_echo[0] = 1'b0;
    for (int i = 0; i < 3; i++) stg_dly[i] = 2;

    // Abort during STORE at k=40
    clear_mon();
    start = 1'b1;
    found = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (ram_wr_en && res_row == 4'd4 && res_col == 4'd0) begin found = 1; break; end
    end
    check("abort_reach_k40", found, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy",  32'(busy), 0);
    check("abort_wr_en", 32'(ram_wr_en), 0);
    repeat (5) @(negedge clk);
    check("abort_writes", wr_cnt, 40);
    check("abort_done",   done_cnt, 0);
    check("abort_mem139", 32'(mem[139]), 32'(exp_res(39)));
    check("abort_mem140", 32'(mem[140]), 32'h0000DEAD);
    $display("abort in STORE: writes=%0d done=%0d busy=%0d", wr_cnt, done_cnt, busy);
    run_pass(1);
    check("post_abort_done",   done_cnt, 1);
    check("post_abort_writes", wr_cnt, 100);
    $display("pass after abort: done=%0d writes=%0d", done_cnt, wr_cnt);

    // Asynchronous reset in the middle of LOAD
    clear_mon();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    check("mid_load_busy", 32'(busy), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy",   32'(busy), 0);
    check("arst_rd_en",  32'(ram_rd_en), 0);
    check("arst_ld_val", 32'(ld_valid), 0);
    check("arst_addr",   32'(ram_addr), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("arst_idle", 32'(busy), 0);
    $display("async reset mid-LOAD: busy=%0d rd_en=%0d", busy, ram_rd_en);
    run_pass(1);
    check("post_rst_done", done_cnt, 1);
    check("post_rst_ld",   ld_beats, 100);
    $display("pass after reset: done=%0d ld=%0d", done_cnt, ld_beats);

    // Stage that never completes
    clear_mon();
    stg_never[1] = 1'b1;
    start = 1'b1;
    found = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (relu_start) begin found = 1; break; end
    end
    check("relu_reached", found, 1);
`ifdef NPU_SEQ_WATCHDOG_EN
    repeat (15) @(negedge clk);
    check("wd_err_c15",  32'(err), 0);
    check("wd_busy_c15", 32'(busy), 1);
    @(negedge clk);
    check("wd_err_c16",  32'(err), 1);
    @(negedge clk);
    check("wd_idle",     32'(busy), 0);
    repeat (3) @(negedge clk);
    check("wd_err_sticky", 32'(err), 1);
    check("wd_no_done",    done_cnt, 0);
    stg_never[1] = 1'b0;
    start = 1'b1;
    @(negedge clk);
    check("wd_err_clear", 32'(err), 0);
    check("wd_restart",   32'(busy), 1);
    $display("watchdog: err raised at cycle 16 of RELU, cleared by new start");
`else
    repeat (40) @(negedge clk);
    check("nowd_busy", 32'(busy), 1);
    check("nowd_err",  32'(err), 0);
    check("nowd_done", done_cnt, 0);
    stg_never[1] = 1'b0;
    $display("no watchdog: stage waited on, busy=%0d err=%0d", busy, err);
`endif
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("final_abort_idle", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

endmodule
